// File: rtl/word_packer_pkg.sv
// Shared widths, state encoding and byte-pair packing helper for word_packer.
package word_packer_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    HALF      = 2'd1,
    FULL      = 2'd2,
    FULL_HALF = 2'd3
  } packer_state_t;

  // Join two bytes in arrival order into one output word.
  function automatic logic [WORD_W-1:0] pack_pair(
    input logic [BYTE_W-1:0] first_byte,
    input logic [BYTE_W-1:0] second_byte,
    input bit                lsb_first
  );
    if (lsb_first) begin
      return {second_byte, first_byte};
    end
    return {first_byte, second_byte};
  endfunction

endpackage

// File: rtl/word_packer_if.sv
// Byte-in / word-out handshake bundle plus flush strobe and status of word_packer.
interface word_packer_if
  import word_packer_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic              clr;
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] data;
  logic              out_valid;
  logic              out_ready;
  logic              clr_done;
  logic [CNT_W-1:0]  word_cnt;
  logic              busy;

  // Producer/consumer side that drives the byte stream and takes the words.
  modport master (
    output clr, in_data, in_valid, out_ready,
    input  in_ready, data, out_valid, clr_done, word_cnt, busy
  );

  modport slave (
    input  clr, in_data, in_valid, out_ready,
    output in_ready, data, out_valid, clr_done, word_cnt, busy
  );

endinterface

// File: rtl/word_packer.sv
// Packs an 8-bit valid/ready byte stream into 16-bit valid/ready words through a
// one-word-plus-one-byte buffer; clr flushes everything and zeroes data before clr_done.
module word_packer
  import word_packer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  word_packer_if.slave  bus
);

  packer_state_t     state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              clr_done_q;

  logic              in_ready;
  logic              accept;
  logic              drain;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    lo_d       = lo_q;
    word_cnt_d = word_cnt_q;

    // Ready depends only on state, clr and reset so it never loops back through in_valid.
    in_ready = reset && !bus.clr && (state_q != FULL_HALF);
    accept   = bus.in_valid && in_ready;
    drain    = out_valid_q && bus.out_ready;

    if (bus.clr) begin
      state_d    = EMPTY;
      data_d     = '0;
      lo_d       = '0;
      word_cnt_d = '0;
    end else begin
      if (drain) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            lo_d    = bus.in_data;
            state_d = HALF;
          end
        end
        HALF: begin
          if (accept) begin
            data_d  = pack_pair(lo_q, bus.in_data, LSB_FIRST);
            state_d = FULL;
          end
        end
        FULL: begin
          if (drain && accept) begin
            lo_d    = bus.in_data;
            state_d = HALF;
          end else if (drain) begin
            state_d = EMPTY;
          end else if (accept) begin
            lo_d    = bus.in_data;
            state_d = FULL_HALF;
          end
        end
        FULL_HALF: begin
          // The byte already held becomes the first half of the next word.
          if (drain) begin
            state_d = HALF;
          end
        end
      endcase
    end

    out_valid_d = (state_d == FULL) || (state_d == FULL_HALF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      lo_q        <= '0;
      word_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      lo_q        <= lo_d;
      word_cnt_q  <= word_cnt_d;
      out_valid_q <= out_valid_d;
      clr_done_q  <= bus.clr;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.data      = data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.busy      = (state_q != EMPTY);

endmodule

// File: tb/tb_word_packer.sv
// Drives two packers (LSB-first/8-bit count and MSB-first/2-bit count) with one shared
// stream and compares both against a byte-queue reference model every cycle.
module tb_word_packer;
  import word_packer_pkg::*;

  logic       clk;
  logic       reset;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  int checks;
  int errors;

  // Reference model: one optional completed word plus a queue of unpaired bytes.
  bit          m_present;
  logic [7:0]  m_pend[$];
  logic [15:0] m_word_lsb;
  logic [15:0] m_word_msb;
  int          m_cnt;
  bit          m_clr_done;

  word_packer_if #(.CNT_W(8)) bus0 ();
  word_packer_if #(.CNT_W(2)) bus1 ();

  assign bus0.clr       = clr;
  assign bus0.in_data   = in_data;
  assign bus0.in_valid  = in_valid;
  assign bus0.out_ready = out_ready;
  assign bus1.clr       = clr;
  assign bus1.in_data   = in_data;
  assign bus1.in_valid  = in_valid;
  assign bus1.out_ready = out_ready;

  word_packer #(.LSB_FIRST(1'b1), .CNT_W(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  word_packer #(.LSB_FIRST(1'b0), .CNT_W(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit c);
    // Buffer holds at most one word plus one byte.
    return !c && !(m_present && m_pend.size() == 1);
  endfunction

  task automatic model_flush(input bit via_clr);
    m_present  = 1'b0;
    m_pend.delete();
    m_word_lsb = 16'h0;
    m_word_msb = 16'h0;
    m_cnt      = 0;
    m_clr_done = via_clr;
  endtask

  task automatic check_outputs();
    chk("d0_data",      32'(bus0.data),      32'(m_word_lsb));
    chk("d1_data",      32'(bus1.data),      32'(m_word_msb));
    chk("d0_out_valid", 32'(bus0.out_valid), 32'(m_present));
    chk("d1_out_valid", 32'(bus1.out_valid), 32'(m_present));
    chk("d0_clr_done",  32'(bus0.clr_done),  32'(m_clr_done));
    chk("d1_clr_done",  32'(bus1.clr_done),  32'(m_clr_done));
    chk("d0_word_cnt",  32'(bus0.word_cnt),  32'(m_cnt % 256));
    chk("d1_word_cnt",  32'(bus1.word_cnt),  32'(m_cnt % 4));
    chk("d0_busy",      32'(bus0.busy),      32'(m_present || m_pend.size() != 0));
    chk("d1_busy",      32'(bus1.busy),      32'(m_present || m_pend.size() != 0));
  endtask

  // One clock cycle: apply inputs, check ready, clock, update model, check outputs.
  task automatic step(input bit c, input bit v, input logic [7:0] d, input bit r);
    bit acc;
    bit drn;
    clr       = c;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    chk("d0_in_ready", 32'(bus0.in_ready), 32'(model_ready(c)));
    chk("d1_in_ready", 32'(bus1.in_ready), 32'(model_ready(c)));
    acc = v && model_ready(c);
    drn = m_present && r;
    @(posedge clk);
    if (c) begin
      model_flush(1'b1);
    end else begin
      if (drn) begin
        m_present = 1'b0;
        m_cnt++;
      end
      if (acc) m_pend.push_back(d);
      if (!m_present && m_pend.size() == 2) begin
        m_word_lsb = {m_pend[1], m_pend[0]};
        m_word_msb = {m_pend[0], m_pend[1]};
        m_present  = 1'b1;
        m_pend.delete();
      end
      m_clr_done = 1'b0;
    end
    #1;
    $display("cyc clr=%0b v=%0b d=%02h rdy=%0b acc=%0b drn=%0b data0=%04h data1=%04h cnt0=%0d",
             c, v, d, r, acc, drn, bus0.data, bus1.data, bus0.word_cnt);
    check_outputs();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    clr       = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_flush(1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus0.in_ready), 32'h0);
    check_outputs();
    reset = 1'b1;

    // 34, 12 with consumer ready
    step(0, 1, 8'h34, 1);
    step(0, 1, 8'h12, 1);
    chk("lsb_word", 32'(bus0.data), 32'h1234);
    chk("msb_word", 32'(bus1.data), 32'h3412);
    chk("word_valid", 32'(bus0.out_valid), 32'h1);
    step(0, 0, 8'h00, 1);
    chk("first_cnt", 32'(bus0.word_cnt), 32'h1);

    // Stall with three bytes buffered, then drain and resume
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'hAA, 0);
    step(0, 1, 8'hBB, 0);
    step(0, 1, 8'hCC, 0);
    step(0, 1, 8'hDD, 0);
    chk("full_half_stall", 32'(bus0.in_ready), 32'h0);
    chk("held_word", 32'(bus0.data), 32'hBBAA);
    step(0, 1, 8'hDD, 1);
    step(0, 1, 8'hDD, 1);
    chk("resume_word", 32'(bus0.data), 32'hDDCC);
    step(0, 0, 8'h00, 1);

    // Flush while a word is waiting
    step(0, 1, 8'hEF, 0);
    step(0, 1, 8'hBE, 0);
    chk("beef_word", 32'(bus0.data), 32'hBEEF);
    step(1, 1, 8'h11, 1);
    chk("clr_data", 32'(bus0.data), 32'h0);
    chk("clr_done_hi", 32'(bus0.clr_done), 32'h1);
    chk("clr_cnt", 32'(bus0.word_cnt), 32'h0);
    step(0, 1, 8'h22, 0);
    chk("clr_done_lo", 32'(bus0.clr_done), 32'h0);

    // Asynchronous reset with one byte held
    reset = 1'b0;
    #1;
    chk("async_busy", 32'(bus0.busy), 32'h0);
    chk("async_in_ready", 32'(bus0.in_ready), 32'h0);
    model_flush(1'b0);
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 1, 8'h56, 0);
    step(0, 1, 8'h78, 0);
    chk("post_reset_word", 32'(bus0.data), 32'h7856);
    step(0, 0, 8'h00, 1);

    // Counter wrap on the 2-bit instance
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'(i * 17 + 3), 1);
    step(0, 0, 8'h00, 1);
    chk("wrap_cnt8", 32'(bus0.word_cnt), 32'd5);
    chk("wrap_cnt2", 32'(bus1.word_cnt), 32'd1);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
           8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
